// File: rtl/fifo_sync_onehot_pkg.sv
// Shared constants and helpers for fifo_sync_onehot.
// Holds the default configuration (DEF_*), the matching DEPTH and PTR_W, and ptr_next, which
// advances a wrap-bit pointer of any width up to 31 address bits.
package fifo_sync_onehot_pkg;

  localparam int unsigned DEF_DW        = 8;
  localparam int unsigned DEF_AW        = 10;
  localparam int unsigned DEF_AF_THRESH = 1020;
  localparam int unsigned DEPTH         = 2 ** DEF_AW;
  localparam int unsigned PTR_W         = DEF_AW + 1;

  // Increment a pointer of aw address bits plus one wrap bit. Bits above the wrap bit are cleared,
  // so the wrap bit toggles each time the address rolls over from 2**aw-1 to 0.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/fifo_sync_onehot_if.sv
// Push/pop bundle for fifo_sync_onehot.
// master: producer/consumer side; drives wr_en, wr_data and rd_en.
// slave:  the FIFO; drives read data, the status flags, the occupancy count and the word-line view.
interface fifo_sync_onehot_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
);
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              rd_en;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       count;
  logic [2**AW-1:0]  wr_line;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, count, wr_line, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, count, wr_line, overflow, underflow
  );
endinterface

// File: rtl/fifo_onehot_decoder.sv
// Generic one-hot word-line decoder: line[i] = en && (addr == i).
// Ports: addr (AW-bit word address), en (line enable), line (2**AW one-hot word lines).
module fifo_onehot_decoder #(
  parameter int unsigned AW = 10
) (
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [2**AW-1:0] line
);

  for (genvar i = 0; i < 2 ** AW; i++) begin : g_line
    assign line[i] = en && (addr == AW'(i));
  end

endmodule

// File: rtl/fifo_sync_onehot.sv
// Parametrised synchronous FIFO with one-hot word-line writes and a registered read port.
// Ports: clk (rising edge), rst (synchronous, active high), fifo (slave modport): wr_en/wr_data
// push, rd_en pop, rd_data/rd_valid registered pop result, full/empty/almost_full/count occupancy,
// wr_line one-hot write strobe, overflow/underflow sticky error flags.
module fifo_sync_onehot
  import fifo_sync_onehot_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned AF_THRESH = DEF_AF_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sync_onehot_if.slave fifo
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned PtrW  = AW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, push, pop;
  logic [Depth-1:0] wr_line;
  logic [DW-1:0]    mem_q [Depth];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Reset masks both strobes so no word line fires while rst is high.
  assign pop  = fifo.rd_en && !empty && !rst;
  assign push = fifo.wr_en && (!full || pop) && !rst;

  fifo_onehot_decoder #(
    .AW (AW)
  ) u_decoder (
    .addr (wr_ptr_q[AW-1:0]),
    .en   (push),
    .line (wr_line)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = pop;
    overflow_d  = overflow_q | (fifo.wr_en && full && !pop);
    underflow_d = underflow_q | (fifo.rd_en && empty);
    if (pop) begin
      rd_ptr_d  = PtrW'(ptr_next(32'(rd_ptr_q), AW));
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
    if (push) begin
      wr_ptr_d = PtrW'(ptr_next(32'(wr_ptr_q), AW));
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + PtrW'(1);
      2'b01:   count_d = count_q - PtrW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; each word loads only on its own word line.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) begin
      if (wr_line[i]) begin
        mem_q[i] <= fifo.wr_data;
      end
    end
  end

  assign fifo.rd_data     = rd_data_q;
  assign fifo.rd_valid    = rd_valid_q;
  assign fifo.full        = full;
  assign fifo.empty       = empty;
  assign fifo.almost_full = (32'(count_q) >= AF_THRESH);
  assign fifo.count       = count_q;
  assign fifo.wr_line     = wr_line;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_sync_onehot.sv
// Directed bench for fifo_sync_onehot (DW=8, AW=2, AF_THRESH=3) with a queue-based reference
// model: accepted pops move the model's head word into a scoreboard that the read port must match.
module tb_fifo_sync_onehot;

  localparam int unsigned Dw = 8;
  localparam int unsigned Aw = 2;
  localparam int unsigned Depth = 4;
  localparam int unsigned AfThresh = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_sync_onehot_if #(.DW(Dw), .AW(Aw)) bus ();

  fifo_sync_onehot #(
    .DW        (Dw),
    .AW        (Aw),
    .AF_THRESH (AfThresh)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [7:0] mdl[$];
  logic [7:0] exp_rd[$];
  int         m_wptr;
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [7:0] e;
    chk("count", 32'(bus.count), 32'(mdl.size()));
    chk("empty", 32'(bus.empty), 32'(mdl.size() == 0));
    chk("full", 32'(bus.full), 32'(mdl.size() == Depth));
    chk("almost_full", 32'(bus.almost_full), 32'(mdl.size() >= AfThresh));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
    if (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      chk("rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'(e));
    end else begin
      chk("rd_valid", 32'(bus.rd_valid), 32'd0);
    end
  endtask

  // One clock of stimulus: drive at negedge, check the word line, update model, check after edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic m_empty, m_full, m_pop, m_push;
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = w;
    bus.wr_data = d;
    bus.rd_en = r;
    m_empty = (mdl.size() == 0);
    m_full  = (mdl.size() == Depth);
    m_pop   = r && !m_empty;
    m_push  = w && (!m_full || m_pop);
    #1;
    chk("wr_line", 32'(bus.wr_line), m_push ? (32'd1 << m_wptr) : 32'd0);
    if (m_pop) exp_rd.push_back(mdl.pop_front());
    if (m_push) begin
      mdl.push_back(d);
      m_wptr = (m_wptr + 1) % Depth;
    end
    if (w && m_full && !m_pop) m_ovf = 1'b1;
    if (r && m_empty) m_unf = 1'b1;
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Hold rst for n edges with a push requested; nothing may be written.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    bus.rd_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    mdl.delete();
    exp_rd.delete();
    m_wptr = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("rst_wr_line", 32'(bus.wr_line), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_state();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    m_wptr = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    do_reset(2);

    // Fill and drain
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Wrap-around
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous push and pop on full
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous push and pop on empty
    step(1'b1, 8'h66, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Overflow and mid-operation reset
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset(1);

    // Normal operation after reset
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
